alu_step_sequencer: RTL
=======================

// Module: alu_step_sequencer
// PURPOSE
//  Control sequencer for the datapath. Replaces hand-stepped T0..T4 control with a real FSM:
//  fetch (T0-T2) plus execute (T3-T6) for register ALU instructions.
//  Drives the datapath strobes (e_*, incPC, MDR_read, BusDataSelect, GP_addr, ALU_op).
//  Reports completion with a start/busy/done handshake.
// PARAMETERS
//  GP_ADDR_W    4   GP register address width; IR fields ra/rb/rc are this width
//  IR_W         32  instruction width; opcode = instr[IR_W-1 -: 5], then ra, rb, rc fields
//  MEM_TIMEOUT  16  max T1 wait cycles for mem_ready; 0 = wait forever
//  CONTINUOUS   0   1: from DONE go straight to T0 while start is high
// PORTS
//  clock          in   1          rising-edge clock
//  clear          in   1          asynchronous, active-low reset
//  start          in   1          request one instruction cycle; sampled in IDLE/DONE
//  mem_ready      in   1          memory data valid on Mdatain this cycle
//  instr          in   IR_W       word being loaded into IR; sampled at end of T2
//  busy           out  1          high in every state except IDLE
//  done           out  1          one-cycle pulse in DONE
//  illegal        out  1          with done: opcode not in table
//  timeout        out  1          with done: mem_ready not seen in time
//  e_PC,e_IR,e_Y,e_Z,e_HI,e_LO,e_MDR,e_MAR,e_GP  out 1 each  register load enables
//  incPC, MDR_read, mem_rd  out 1 each  PC increment, MDR mux select, memory read request
//  BusDataSelect  out  5          0 GP, 1 HI, 2 LO, 3 ZHI, 4 ZLO, 5 PC, 6 MDR, 31 none
//  GP_addr        out  GP_ADDR_W  GP register read/write address
//  ALU_op         out  4          0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 6 NEG, 7 NOT
// BEHAVIOUR
//  - Moore FSM. All outputs decode from the registered state and latched IR fields.
//  - Any strobe not listed for a state is 0.
//  - Reset, including mid-instruction, forces these values:
//      state=IDLE; all strobes/flags 0; BusDataSelect=31; GP_addr=0; ALU_op=0; wait counter=0.
//  - Opcodes (5b): ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000,
//    NEG 10001, NOT 10010.
//  - IDLE: start=1 -> T0. start while busy is ignored.
//  - T0: BusDataSelect=PC, e_MAR, incPC -> T1.
//  - T1: mem_rd, MDR_read, e_MDR held high.
//      mem_ready=1 -> T2.
//      Else the wait counter increments.
//      Counter reaches MEM_TIMEOUT (when non-zero) -> DONE with timeout=1.
//  - T2: BusDataSelect=MDR, e_IR -> T3. instr latched into internal IR on the same edge.
//  - T3: illegal opcode -> DONE with illegal=1.
//      NEG/NOT: GP_addr=rb, BusDataSelect=GP, ALU_op, e_Z -> T4.
//      Others: GP_addr=rb, BusDataSelect=GP, e_Y -> T4.
//  - T4: NEG/NOT: BusDataSelect=ZLO, GP_addr=ra, e_GP -> DONE.
//      Others: GP_addr=rc, BusDataSelect=GP, ALU_op, e_Z -> T5.
//  - T5: ADD/SUB/AND/OR: BusDataSelect=ZLO, GP_addr=ra, e_GP -> DONE.
//      MUL/DIV: BusDataSelect=ZLO, e_LO -> T6.
//  - T6: BusDataSelect=ZHI, e_HI -> DONE.
//  - DONE: done=1 for exactly one cycle; illegal/timeout valid this cycle only.
//      Next state: T0 if CONTINUOUS=1 and start=1, else IDLE.
//  - Latency, start to done (no memory wait): NEG/NOT 6, ADD..OR 7, MUL/DIV 8 cycles.
//      Each mem_ready wait cycle adds 1.
//  - mem_ready and clear asserted together: clear wins.
//  - Counter resets on T1 entry and does not wrap.
// TESTING
//  - NOT R2,R3 (instr=0x9100_0000 | rb=3 field), mem_ready in T1 -> strobe sequence T0..T4;
//    done on cycle 6; GP_addr=3 in T3, 2 in T4; ALU_op=7.
//  - ADD R5,R1,R2, mem_ready delayed 3 cycles -> done on cycle 10;
//    e_Y in T3 with GP_addr=1, e_Z in T4 with GP_addr=2, e_GP in T5 with GP_addr=5.
//  - MUL R0,R6,R7 -> e_LO in T5, e_HI in T6, e_GP never asserted, done on cycle 8.
//  - opcode 11111 -> done and illegal both 1 in the cycle after T3; no e_Y/e_Z/e_GP pulse.
//  - mem_ready held 0, MEM_TIMEOUT=16 -> done and timeout after 16 T1 cycles; then IDLE.
//  - clear driven 0 during T4 of ADD -> outputs at reset values immediately,
//    asynchronously; start after release runs a clean fetch.
//  - CONTINUOUS=1, start held -> T0 directly follows DONE; two NOTs complete in 12 cycles.

Source files
------------

// File: rtl/alu_step_sequencer.sv
// Fetch/execute control FSM for the register-ALU datapath.
// Every output is registered and reflects the state and IR fields latched on the same edge.
module alu_step_sequencer #(
    parameter int GP_ADDR_W   = 4,
    parameter int IR_W        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 mem_ready,
    input  logic [IR_W-1:0]      instr,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic                 timeout,
    output logic                 e_PC,
    output logic                 e_IR,
    output logic                 e_Y,
    output logic                 e_Z,
    output logic                 e_HI,
    output logic                 e_LO,
    output logic                 e_MDR,
    output logic                 e_MAR,
    output logic                 e_GP,
    output logic                 incPC,
    output logic                 MDR_read,
    output logic                 mem_rd,
    output logic [4:0]           BusDataSelect,
    output logic [GP_ADDR_W-1:0] GP_addr,
    output logic [3:0]           ALU_op
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam int RA_HI = IR_W - 6;
    localparam int RB_HI = RA_HI - GP_ADDR_W;
    localparam int RC_HI = RB_HI - GP_ADDR_W;
    localparam int RC_LO = RC_HI - GP_ADDR_W + 1;

    localparam logic [4:0] BUS_GP   = 5'd0;
    localparam logic [4:0] BUS_HI   = 5'd1;
    localparam logic [4:0] BUS_LO   = 5'd2;
    localparam logic [4:0] BUS_ZHI  = 5'd3;
    localparam logic [4:0] BUS_ZLO  = 5'd4;
    localparam logic [4:0] BUS_PC   = 5'd5;
    localparam logic [4:0] BUS_MDR  = 5'd6;
    localparam logic [4:0] BUS_NONE = 5'd31;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 e_pc;
        logic                 e_ir;
        logic                 e_y;
        logic                 e_z;
        logic                 e_hi;
        logic                 e_lo;
        logic                 e_mdr;
        logic                 e_mar;
        logic                 e_gp;
        logic                 inc_pc;
        logic                 mdr_read;
        logic                 mem_rd;
        logic [4:0]           bus;
        logic [GP_ADDR_W-1:0] gp;
        logic [3:0]           alu;
    } ctl_t;

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
               is_muldiv(op) || is_unary(op);
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return 4'd0;
            OP_SUB:  return 4'd1;
            OP_AND:  return 4'd2;
            OP_OR:   return 4'd3;
            OP_MUL:  return 4'd4;
            OP_DIV:  return 4'd5;
            OP_NEG:  return 4'd6;
            OP_NOT:  return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    // Strobe decode for a state; IDLE yields the reset image (bus parked at none).
    function automatic ctl_t decode(input state_t s, input logic [4:0] op,
                                    input logic [GP_ADDR_W-1:0] ra,
                                    input logic [GP_ADDR_W-1:0] rb,
                                    input logic [GP_ADDR_W-1:0] rc);
        ctl_t c;
        c      = '0;
        c.bus  = BUS_NONE;
        c.busy = (s != S_IDLE);
        case (s)
            S_T0: begin
                c.bus    = BUS_PC;
                c.e_mar  = 1'b1;
                c.inc_pc = 1'b1;
            end
            S_T1: begin
                c.mem_rd   = 1'b1;
                c.mdr_read = 1'b1;
                c.e_mdr    = 1'b1;
            end
            S_T2: begin
                c.bus  = BUS_MDR;
                c.e_ir = 1'b1;
            end
            S_T3: begin
                if (is_legal(op)) begin
                    c.gp  = rb;
                    c.bus = BUS_GP;
                    if (is_unary(op)) begin
                        c.alu = alu_code(op);
                        c.e_z = 1'b1;
                    end else begin
                        c.e_y = 1'b1;
                    end
                end
            end
            S_T4: begin
                if (is_unary(op)) begin
                    c.bus  = BUS_ZLO;
                    c.gp   = ra;
                    c.e_gp = 1'b1;
                end else begin
                    c.gp  = rc;
                    c.bus = BUS_GP;
                    c.alu = alu_code(op);
                    c.e_z = 1'b1;
                end
            end
            S_T5: begin
                c.bus = BUS_ZLO;
                if (is_muldiv(op)) begin
                    c.e_lo = 1'b1;
                end else begin
                    c.gp   = ra;
                    c.e_gp = 1'b1;
                end
            end
            S_T6: begin
                c.bus  = BUS_ZHI;
                c.e_hi = 1'b1;
            end
            S_DONE: c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [4:0]           opc, opc_nxt;
    logic [GP_ADDR_W-1:0] ra, ra_nxt, rb, rb_nxt, rc, rc_nxt;
    logic                 ill_nxt, to_nxt;
    ctl_t                 ctl;
    logic                 unused_ir_bits;

    assign unused_ir_bits = ^instr[RC_LO-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        opc_nxt   = opc;
        ra_nxt    = ra;
        rb_nxt    = rb;
        rc_nxt    = rc;
        ill_nxt   = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_T0;
            S_T0: begin
                state_nxt = S_T1;
                cnt_nxt   = '0;
            end
            S_T1: begin
                // A ready on the last permitted cycle still counts as a hit.
                if (mem_ready) begin
                    state_nxt = S_T2;
                end else if ((MEM_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    state_nxt = S_DONE;
                    to_nxt    = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_T2: begin
                state_nxt = S_T3;
                opc_nxt   = instr[IR_W-1 -: 5];
                ra_nxt    = instr[RA_HI -: GP_ADDR_W];
                rb_nxt    = instr[RB_HI -: GP_ADDR_W];
                rc_nxt    = instr[RC_HI -: GP_ADDR_W];
            end
            S_T3: begin
                if (!is_legal(opc)) begin
                    state_nxt = S_DONE;
                    ill_nxt   = 1'b1;
                end else begin
                    state_nxt = S_T4;
                end
            end
            S_T4:   state_nxt = is_unary(opc) ? S_DONE : S_T5;
            S_T5:   state_nxt = is_muldiv(opc) ? S_T6 : S_DONE;
            S_T6:   state_nxt = S_DONE;
            S_DONE: state_nxt = (CONTINUOUS && start) ? S_T0 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_IDLE;
            cnt     <= '0;
            opc     <= '0;
            ra      <= '0;
            rb      <= '0;
            rc      <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
            ctl     <= decode(S_IDLE, 5'd0, '0, '0, '0);
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            opc     <= opc_nxt;
            ra      <= ra_nxt;
            rb      <= rb_nxt;
            rc      <= rc_nxt;
            illegal <= ill_nxt;
            timeout <= to_nxt;
            ctl     <= decode(state_nxt, opc_nxt, ra_nxt, rb_nxt, rc_nxt);
        end
    end

    assign busy          = ctl.busy;
    assign done          = ctl.done;
    assign e_PC          = ctl.e_pc;
    assign e_IR          = ctl.e_ir;
    assign e_Y           = ctl.e_y;
    assign e_Z           = ctl.e_z;
    assign e_HI          = ctl.e_hi;
    assign e_LO          = ctl.e_lo;
    assign e_MDR         = ctl.e_mdr;
    assign e_MAR         = ctl.e_mar;
    assign e_GP          = ctl.e_gp;
    assign incPC         = ctl.inc_pc;
    assign MDR_read      = ctl.mdr_read;
    assign mem_rd        = ctl.mem_rd;
    assign BusDataSelect = ctl.bus;
    assign GP_addr       = ctl.gp;
    assign ALU_op        = ctl.alu;

endmodule
